// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;
  localparam int         FRAME_BITS = 11;

endpackage

// File: rtl/ps2_in_sync.sv
// Two-flop synchronizer for a raw PS/2 pin with optional falling-edge detect.
// All flops reset to 1, the idle level of the open-collector bus.
module ps2_in_sync #(
  parameter bit EDGE_DET = 1'b1
) (
  input  logic FPGAClk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic s1;
  logic s2;

  // Two-stage metastability filter.
  always_ff @(posedge FPGAClk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign dout = s2;

  if (EDGE_DET) begin : g_edge
    logic prev;

    // Delayed copy of the synchronized level for edge detection.
    always_ff @(posedge FPGAClk) begin
      if (rst) prev <= 1'b1;
      else     prev <= s2;
    end

    assign fall = prev & ~s2;
  end else begin : g_noedge
    assign fall = 1'b0;
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frames 11-bit PS/2 words, checks odd parity and stop
// bit, folds 0xE0/0xF0 prefixes into flags and emits one pulse per scan code.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       FPGAClk,
  input  logic       rst,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_err
);

  localparam int unsigned     TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic ps2c_fall;
  logic ps2c_sync_unused;
  logic ps2d;
  logic ps2d_fall_unused;

  ps2_in_sync #(.EDGE_DET(1'b1)) u_clk_sync (
    .FPGAClk (FPGAClk),
    .rst     (rst),
    .din     (PS2Clk),
    .dout    (ps2c_sync_unused),
    .fall    (ps2c_fall)
  );

  ps2_in_sync #(.EDGE_DET(1'b0)) u_data_sync (
    .FPGAClk (FPGAClk),
    .rst     (rst),
    .din     (PS2Data),
    .dout    (ps2d),
    .fall    (ps2d_fall_unused)
  );

  ps2_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [7:0]    scan_code_d;
  logic          is_break_d, is_extended_d, code_valid_d, frame_err_d;

  // State, datapath and registered outputs.
  always_ff @(posedge FPGAClk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      scan_code   <= '0;
      is_break    <= 1'b0;
      is_extended <= 1'b0;
      code_valid  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      scan_code   <= scan_code_d;
      is_break    <= is_break_d;
      is_extended <= is_extended_d;
      code_valid  <= code_valid_d;
      frame_err   <= frame_err_d;
    end
  end

  // Next-state, frame decode and timeout; a PS/2 edge takes priority over expiry.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    par_d         = par_q;
    tmo_d         = '0;
    ext_d         = ext_q;
    brk_d         = brk_q;
    scan_code_d   = scan_code;
    is_break_d    = is_break;
    is_extended_d = is_extended;
    code_valid_d  = 1'b0;
    frame_err_d   = 1'b0;

    if (state_q == IDLE) begin
      if (ps2c_fall && !ps2d) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
    end else if (ps2c_fall) begin
      case (state_q)
        DATA: begin
          shreg_d   = {ps2d, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = ps2d;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (ps2d && (^{shreg_q, par_q})) begin
            if (shreg_q == PREFIX_EXT) begin
              ext_d = 1'b1;
            end else if (shreg_q == PREFIX_BRK) begin
              brk_d = 1'b1;
            end else begin
              scan_code_d   = shreg_q;
              is_break_d    = brk_q;
              is_extended_d = ext_q;
              code_valid_d  = 1'b1;
              ext_d         = 1'b0;
              brk_d         = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (tmo_q == TMO_MAX) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

endmodule
